dispatch_ctrl: RTL and testbench
================================

DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

Interface
REQ-001 SHALL have parameter ALU_ENTRIES, default 4, giving the ALU reservation-station capacity.
REQ-002 SHALL have parameter BR_ENTRIES, default 4, giving the branch reservation-station capacity.
REQ-003 SHALL have parameter ROB_ENTRIES, default 8 (power of two), giving the reorder-buffer capacity.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 instrValid  in  1  a decoded instruction is presented this cycle.
REQ-007 stationRequest  in  1  the instruction needs a reservation-station entry.
REQ-008 RSstation  in  2  target station: 00 ALU, 01 branch; 10 and 11 mean no station.
REQ-009 robWrite  in  1  the instruction needs a ROB entry.
REQ-010 aluFree  in  1  one ALU RS entry is released this cycle.
REQ-011 brFree  in  1  one branch RS entry is released this cycle.
REQ-012 robCommit  in  1  the ROB head entry retires this cycle.
REQ-013 flush  in  1  mispredict recovery; discard all in-flight occupancy.
REQ-014 dispatch  out  1  the presented instruction is accepted this cycle.
REQ-015 aluAlloc / brAlloc  out  1 each  an ALU or branch RS entry is allocated this cycle.
REQ-016 stall  out  1  the presented instruction is not accepted; the front end holds it.
REQ-017 robTag  out  log2(ROB_ENTRIES)  ROB tail index given to the dispatching instruction.
REQ-018 aluCount / brCount / robCount  out  clog2(capacity+1) each  current occupancy.

Function
REQ-019 needAlu = stationRequest & (RSstation==00); needBr = stationRequest & (RSstation==01); needRob = robWrite.
REQ-020 A stationRequest with RSstation of 10 or 11 SHALL be treated as needing no station.
REQ-021 The FSM SHALL have two states, RUN and RECOVER; reset enters RUN.
REQ-022 In RUN: stall = instrValid & ((needAlu & aluCount==ALU_ENTRIES) | (needBr & brCount==BR_ENTRIES) | (needRob & robCount==ROB_ENTRIES)).
REQ-023 Fullness SHALL be judged on registered counts only; a same-cycle free or commit SHALL NOT unblock dispatch in that cycle.
REQ-024 In RUN: dispatch = instrValid & ~stall & ~flush; aluAlloc = dispatch & needAlu; brAlloc = dispatch & needBr.
REQ-025 An instruction with no station and no ROB need (e.g. an invalid opcode) SHALL dispatch with no allocation, i.e. be consumed and dropped.
REQ-026 Each count SHALL be updated as next = count + alloc - free; simultaneous alloc and free SHALL leave the count unchanged.
REQ-027 A free or commit arriving when the matching count is 0 SHALL be ignored; the count SHALL NOT underflow.
REQ-028 The ROB allocation term SHALL be dispatch & needRob; the ROB free term SHALL be robCommit & (robCount != 0).
REQ-029 tail SHALL increment modulo ROB_ENTRIES on ROB allocation; head SHALL increment modulo ROB_ENTRIES on a valid commit; robTag SHALL equal tail.
REQ-030 A flush in any state SHALL, on the next edge, zero all counts, head and tail, and enter RECOVER; flush overrides every same-cycle alloc, free and commit.
REQ-031 In RECOVER: dispatch=0, alloc=0, stall=instrValid; the FSM SHALL return to RUN after one cycle unless flush is high again.
REQ-032 All outputs other than counts and robTag SHALL be combinational from the registered state and the current inputs; latency from dispatch to a count change SHALL be one cycle.

Reset
REQ-033 While reset is high: state=RUN, all counts=0, head=tail=0, so robTag=0; dispatch, aluAlloc and brAlloc are 0; stall follows REQ-022 with zero counts, i.e. 0.
REQ-034 Reset asserted mid-operation SHALL clear all state immediately, regardless of the clock.

Verification
REQ-035 Fill ALU RS: 5 back-to-back ALU instructions (stationRequest=1, RSstation=00, robWrite=1) -> dispatches 1-4 get robTag 0,1,2,3; the 5th sees stall=1 with aluCount=4.
REQ-036 At aluCount=4 with the instruction held, pulse aluFree -> stall stays 1 that cycle; the next cycle dispatch=1 and aluCount returns to 4.
REQ-037 Dispatch 8 JAL-like instructions (stationRequest=0, robWrite=1), then commit 1, then dispatch 1 -> robTag of the 9th dispatch = 0 (wrap); robCount=8.
REQ-038 At brCount=2, assert brAlloc and brFree in the same cycle -> brCount stays 2.
REQ-039 With counts 3/2/6, assert flush together with instrValid -> dispatch=0; next cycle state=RECOVER, all counts 0, robTag=0, stall=1; the following cycle is RUN.
REQ-040 robCommit with robCount=0, and an invalid opcode (robWrite=0, RSstation=11) -> counts unchanged; the invalid instruction gets dispatch=1 with no allocation.

Source files
------------

// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: in-order dispatch gate for a single decoded instruction per cycle.
// Tracks ALU RS, branch RS and ROB occupancy, stalls the front end when a needed
// resource is full (judged on registered counts only), allocates RS entries and a
// ROB tail tag on dispatch, and recovers from a flush through a one-cycle RECOVER state.
//
// Ports:
//   clk, reset                   clock and asynchronous active-high reset
//   instrValid                   decoded instruction presented this cycle
//   stationRequest, RSstation    RS need and target (00 ALU, 01 branch, 1x none)
//   robWrite                     instruction needs a ROB entry
//   aluFree, brFree, robCommit   release of one ALU RS, one branch RS, or the ROB head
//   flush                        mispredict recovery, clears all occupancy
//   dispatch, aluAlloc, brAlloc  acceptance and RS allocation strobes
//   stall                        instruction not accepted, front end holds it
//   robTag                       ROB tail index handed to the dispatching instruction
//   aluCount, brCount, robCount  current occupancy
module dispatch_ctrl #(
    parameter int unsigned ALU_ENTRIES = 4,
    parameter int unsigned BR_ENTRIES  = 4,
    parameter int unsigned ROB_ENTRIES = 8,
    localparam int unsigned AluW = $clog2(ALU_ENTRIES + 1),
    localparam int unsigned BrW  = $clog2(BR_ENTRIES + 1),
    localparam int unsigned RobW = $clog2(ROB_ENTRIES + 1),
    localparam int unsigned TagW = $clog2(ROB_ENTRIES)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instrValid,
    input  logic            stationRequest,
    input  logic [1:0]      RSstation,
    input  logic            robWrite,
    input  logic            aluFree,
    input  logic            brFree,
    input  logic            robCommit,
    input  logic            flush,
    output logic            dispatch,
    output logic            aluAlloc,
    output logic            brAlloc,
    output logic            stall,
    output logic [TagW-1:0] robTag,
    output logic [AluW-1:0] aluCount,
    output logic [BrW-1:0]  brCount,
    output logic [RobW-1:0] robCount
);

    localparam logic [AluW-1:0] AluFull = AluW'(ALU_ENTRIES);
    localparam logic [BrW-1:0]  BrFull  = BrW'(BR_ENTRIES);
    localparam logic [RobW-1:0] RobFull = RobW'(ROB_ENTRIES);

    typedef enum logic {StRun, StRecover} state_e;

    state_e            state_q, state_d;
    logic [AluW-1:0]   alu_q, alu_d;
    logic [BrW-1:0]    br_q, br_d;
    logic [RobW-1:0]   rob_q, rob_d;
    logic [TagW-1:0]   head_q, head_d;
    logic [TagW-1:0]   tail_q, tail_d;

    logic need_alu, need_br, need_rob, full;
    logic rob_alloc, alu_rel, br_rel, rob_rel;

    // RSstation 1x requests no station at all.
    assign need_alu = stationRequest & (RSstation == 2'b00);
    assign need_br  = stationRequest & (RSstation == 2'b01);
    assign need_rob = robWrite;

    // Registered counts only: a same-cycle release never unblocks this cycle.
    assign full = (need_alu & (alu_q == AluFull)) |
                  (need_br  & (br_q  == BrFull))  |
                  (need_rob & (rob_q == RobFull));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:     if (flush) state_d = StRecover;
            StRecover: state_d = flush ? StRecover : StRun;
            default:   state_d = StRun;
        endcase
    end

    // Output logic; strobes held low while reset is asserted.
    always_comb begin
        dispatch = 1'b0;
        stall    = 1'b0;
        unique case (state_q)
            StRun: begin
                stall    = instrValid & full;
                dispatch = instrValid & ~full & ~flush & ~reset;
            end
            StRecover: stall = instrValid;
            default: ;
        endcase
        aluAlloc = dispatch & need_alu;
        brAlloc  = dispatch & need_br;
    end

    // Occupancy and ROB pointers; releases against an empty resource are dropped.
    always_comb begin
        rob_alloc = dispatch & need_rob;
        alu_rel   = aluFree   & (alu_q != '0);
        br_rel    = brFree    & (br_q  != '0);
        rob_rel   = robCommit & (rob_q != '0);

        alu_d  = alu_q + AluW'(aluAlloc)  - AluW'(alu_rel);
        br_d   = br_q  + BrW'(brAlloc)    - BrW'(br_rel);
        rob_d  = rob_q + RobW'(rob_alloc) - RobW'(rob_rel);
        head_d = rob_rel   ? head_q + TagW'(1) : head_q;
        tail_d = rob_alloc ? tail_q + TagW'(1) : tail_q;

        if (flush) begin
            alu_d  = '0;
            br_d   = '0;
            rob_d  = '0;
            head_d = '0;
            tail_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_q  <= '0;
            br_q   <= '0;
            rob_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            alu_q  <= alu_d;
            br_q   <= br_d;
            rob_q  <= rob_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign aluCount = alu_q;
    assign brCount  = br_q;
    assign robCount = rob_q;
    assign robTag   = tail_q;

endmodule

// File: tb/tb_dispatch_ctrl.sv
module tb_dispatch_ctrl;

    localparam int AluN = 4;
    localparam int BrN  = 4;
    localparam int RobN = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       instrValid, stationRequest, robWrite;
    logic [1:0] RSstation;
    logic       aluFree, brFree, robCommit, flush;
    logic       dispatch, aluAlloc, brAlloc, stall;
    logic [2:0] robTag;
    logic [2:0] aluCount, brCount;
    logic [3:0] robCount;

    dispatch_ctrl #(
        .ALU_ENTRIES(AluN),
        .BR_ENTRIES (BrN),
        .ROB_ENTRIES(RobN)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .instrValid    (instrValid),
        .stationRequest(stationRequest),
        .RSstation     (RSstation),
        .robWrite      (robWrite),
        .aluFree       (aluFree),
        .brFree        (brFree),
        .robCommit     (robCommit),
        .flush         (flush),
        .dispatch      (dispatch),
        .aluAlloc      (aluAlloc),
        .brAlloc       (brAlloc),
        .stall         (stall),
        .robTag        (robTag),
        .aluCount      (aluCount),
        .brCount       (brCount),
        .robCount      (robCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        int disp; int aa; int ba; int stl; int tag; int ac; int bc; int rc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   checking = 1'b0;
    int   cyc      = 0;

    // Reference model: occupancy numbers, ROB contents as a queue of tags.
    int   m_alu, m_br, m_tail;
    bit   m_rec;
    int   m_rob[$];

    task automatic model_reset();
        m_alu = 0; m_br = 0; m_tail = 0; m_rec = 1'b0;
        m_rob.delete();
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Apply one cycle of inputs at a negedge, push the expected response, advance model.
    task automatic drive(input bit iv, input bit sr, input bit [1:0] st, input bit rw,
                         input bit af, input bit bf, input bit rc, input bit fl);
        exp_t e;
        bit na, nb, nr, blocked;
        instrValid = iv; stationRequest = sr; RSstation = st; robWrite = rw;
        aluFree = af; brFree = bf; robCommit = rc; flush = fl;

        na = sr && (st == 2'd0);
        nb = sr && (st == 2'd1);
        nr = rw;
        blocked = (na && m_alu == AluN) || (nb && m_br == BrN) || (nr && m_rob.size() == RobN);
        if (m_rec) begin
            e.stl  = int'(iv);
            e.disp = 0;
        end else begin
            e.stl  = int'(iv && blocked);
            e.disp = int'(iv && !blocked && !fl);
        end
        e.aa  = int'(e.disp == 1 && na);
        e.ba  = int'(e.disp == 1 && nb);
        e.tag = m_tail;
        e.ac  = m_alu;
        e.bc  = m_br;
        e.rc  = m_rob.size();
        sb.push_back(e);

        if (fl) begin
            model_reset();
            m_rec = 1'b1;
        end else begin
            m_rec = 1'b0;
            if (af && m_alu > 0) m_alu--;
            if (bf && m_br > 0) m_br--;
            if (rc && m_rob.size() > 0) void'(m_rob.pop_front());
            if (e.aa == 1) m_alu++;
            if (e.ba == 1) m_br++;
            if (e.disp == 1 && nr) begin
                m_rob.push_back(m_tail);
                m_tail = (m_tail + 1) % RobN;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 0, 2'd0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares the DUT against the oldest expected entry each checked cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (checking) begin
                if (sb.size() == 0) begin
                    check("scoreboard_empty", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("dispatch", int'(dispatch), e.disp);
                    check("aluAlloc", int'(aluAlloc), e.aa);
                    check("brAlloc",  int'(brAlloc),  e.ba);
                    check("stall",    int'(stall),    e.stl);
                    check("robTag",   int'(robTag),   e.tag);
                    check("aluCount", int'(aluCount), e.ac);
                    check("brCount",  int'(brCount),  e.bc);
                    check("robCount", int'(robCount), e.rc);
                end
            end
        end
    end

    initial begin
        // Reset with an ALU+ROB instruction presented: nothing may dispatch.
        reset = 1'b1;
        instrValid = 1; stationRequest = 1; RSstation = 2'd0; robWrite = 1;
        aluFree = 0; brFree = 0; robCommit = 0; flush = 0;
        model_reset();
        #13;
        check("rst_dispatch", int'(dispatch), 0);
        check("rst_aluAlloc", int'(aluAlloc), 0);
        check("rst_stall",    int'(stall),    0);
        check("rst_robTag",   int'(robTag),   0);
        check("rst_counts",   int'(aluCount) + int'(brCount) + int'(robCount), 0);
        @(negedge clk);
        reset = 1'b0;
        checking = 1'b1;

        // Fill ALU RS, then hold the 6th with an aluFree pulse, then retry.
        repeat (5) drive(1, 1, 2'd0, 1, 0, 0, 0, 0);
        drive(1, 1, 2'd0, 1, 1, 0, 0, 0);
        drive(1, 1, 2'd0, 1, 0, 0, 0, 0);
        drive(1, 1, 2'd0, 1, 0, 0, 0, 0);
        drive(0, 0, 2'd0, 0, 0, 0, 0, 1);
        idle();

        // ROB wrap: 8 JAL-like, a 9th blocked, commit one, then dispatch.
        repeat (9) drive(1, 0, 2'd0, 1, 0, 0, 0, 0);
        drive(0, 0, 2'd0, 0, 0, 0, 1, 0);
        drive(1, 0, 2'd0, 1, 0, 0, 0, 0);
        idle();
        drive(0, 0, 2'd0, 0, 0, 0, 0, 1);
        idle();

        // Branch alloc and free in the same cycle at brCount=2.
        repeat (2) drive(1, 1, 2'd1, 0, 0, 0, 0, 0);
        drive(1, 1, 2'd1, 0, 0, 1, 0, 0);
        idle();
        drive(0, 0, 2'd0, 0, 0, 0, 0, 1);
        idle();

        // Counts 3/2/6, flush with a valid instruction, RECOVER stalls, then RUN.
        repeat (3) drive(1, 1, 2'd0, 1, 0, 0, 0, 0);
        repeat (2) drive(1, 1, 2'd1, 1, 0, 0, 0, 0);
        drive(1, 0, 2'd0, 1, 0, 0, 0, 0);
        drive(1, 1, 2'd0, 1, 0, 0, 0, 1);
        drive(1, 1, 2'd0, 1, 0, 0, 0, 0);
        drive(1, 1, 2'd0, 1, 0, 0, 0, 0);
        idle();
        drive(0, 0, 2'd0, 0, 0, 0, 0, 1);
        drive(0, 0, 2'd0, 0, 0, 0, 0, 1);
        idle();

        // Empty-ROB commit and frees are ignored; invalid opcode is consumed.
        drive(0, 0, 2'd0, 0, 1, 1, 1, 0);
        drive(1, 1, 2'd3, 0, 0, 0, 1, 0);
        drive(1, 1, 2'd2, 0, 0, 0, 0, 0);
        idle();

        // Asynchronous reset mid-operation.
        repeat (3) drive(1, 1, 2'd1, 1, 0, 0, 0, 0);
        checking = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_brCount",  int'(brCount),  0);
        check("async_rst_robCount", int'(robCount), 0);
        check("async_rst_robTag",   int'(robTag),   0);
        check("async_rst_dispatch", int'(dispatch), 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        checking = 1'b1;

        // Random traffic: a congested phase, then a free-flowing phase.
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 1500; i++) begin
                int rel;
                rel = (ph == 0) ? 15 : 45;
                drive($urandom_range(99) < 80, $urandom_range(99) < 75,
                      2'($urandom_range(3)), $urandom_range(99) < 70,
                      $urandom_range(99) < rel, $urandom_range(99) < rel,
                      $urandom_range(99) < rel, $urandom_range(99) < 3);
            end
        end
        checking = 1'b0;
        #5;
        if (sb.size() != 0) check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
